// File: rtl/spi_txn_arbiter.sv
// Round-robin transaction arbiter sharing one SPI master engine among NUM_REQ requesters.
// Sequences the engine handshake and returns done/err pulses and read data to the owner.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for any req; picks winner from rr_ptr
// LOAD   | grant asserted; write word presented with one data_valid
// XFER   | engine enable held until matching done or timeout
// DONE   | done (and err on abort) pulse to the owner
// GAP    | engine quiet time before the next arbitration
module spi_txn_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int WORD_SIZE  = 8,
   parameter int TIMEOUT    = 64,
   parameter int GAP_CYCLES = 2
) (
   input  logic                           sclk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0]             req_rd,
   input  logic [NUM_REQ*WORD_SIZE-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [NUM_REQ-1:0]             done,
   output logic [NUM_REQ-1:0]             err,
   output logic [WORD_SIZE-1:0]           rdata,
   output logic                           busy,
   output logic [WORD_SIZE-1:0]           eng_data_in,
   output logic                           eng_data_valid,
   output logic                           eng_tx_en,
   output logic                           eng_rx_en,
   input  logic                           eng_tx_done,
   input  logic                           eng_rx_done,
   input  logic [WORD_SIZE-1:0]           eng_data_out
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_XFER = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_GAP  = 3'd4;

   logic [2:0]         state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   win_idx;
   logic               win_rd;
   logic               abort;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [GAP_W-1:0]   gap_cnt;

   logic [PTR_W-1:0]   pick_idx;
   logic               pick_vld;
   logic [PTR_W:0]     cand;
   logic               xfer_hit;
   logic [NUM_REQ-1:0] win_onehot;

   // Scan downward so the candidate closest to rr_ptr overwrites the others.
   always_comb begin
      pick_idx = '0;
      pick_vld = 1'b0;
      cand     = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         cand = {1'b0, rr_ptr} + (PTR_W + 1)'(j);
         if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
         if (req[cand[PTR_W-1:0]]) begin
            pick_idx = cand[PTR_W-1:0];
            pick_vld = 1'b1;
         end
      end
   end

   assign xfer_hit = win_rd ? eng_rx_done : eng_tx_done;

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         rr_ptr      <= '0;
         win_idx     <= '0;
         win_rd      <= 1'b0;
         abort       <= 1'b0;
         tmo_cnt     <= '0;
         gap_cnt     <= '0;
         rdata       <= '0;
         eng_data_in <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               tmo_cnt <= '0;
               if (pick_vld) begin
                  win_idx <= pick_idx;
                  win_rd  <= req_rd[pick_idx];
                  abort   <= 1'b0;
                  if (!req_rd[pick_idx])
                     eng_data_in <= req_wdata[pick_idx*WORD_SIZE +: WORD_SIZE];
                  state   <= S_LOAD;
               end
            end
            S_LOAD: begin
               rr_ptr  <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
               tmo_cnt <= '0;
               state   <= S_XFER;
            end
            S_XFER: begin
               // A done arriving on the last allowed cycle still counts as success.
               if (xfer_hit) begin
                  if (win_rd) rdata <= eng_data_out;
                  state <= S_DONE;
               end else if (tmo_cnt == TMO_LAST) begin
                  abort <= 1'b1;
                  state <= S_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_DONE: begin
               gap_cnt <= GAP_LAST;
               state   <= S_GAP;
            end
            S_GAP: begin
               tmo_cnt <= '0;
               if (gap_cnt == '0) state <= S_IDLE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign win_onehot = NUM_REQ'(1) << win_idx;

   always_comb begin
      gnt            = '0;
      done           = '0;
      err            = '0;
      eng_data_valid = 1'b0;
      eng_tx_en      = 1'b0;
      eng_rx_en      = 1'b0;
      busy           = (state != S_IDLE);
      if (state == S_LOAD || state == S_XFER || state == S_DONE) gnt = win_onehot;
      if (state == S_LOAD) eng_data_valid = !win_rd;
      if (state == S_XFER) begin
         eng_tx_en = !win_rd;
         eng_rx_en = win_rd;
      end
      if (state == S_DONE) begin
         done = win_onehot;
         if (abort) err = win_onehot;
      end
   end

endmodule
